cordic_fsm_v3: RTL and testbench

Parametrised control FSM for the iterative CORDIC sine/cosine datapath and the successor to the v2 controller. The iteration and variable counters are internal, so the datapath no longer supplies tick signals. Adds a run-time rotation/vectoring mode, a configurable iteration count, a timeout watchdog on the add/subtract handshake, and a busy indication. It sits between the requesting module (start/ready/ACK) and the datapath (mux selects, register enables, add/subtract handshake).

---
 rtl/cordic_pkg.sv | 60 ++++++
 rtl/cordic_iter_counter.sv | 39 +++
 rtl/cordic_fsm_v3.sv | 249 ++++++++++++++++++++++++
 tb/tb_cordic_fsm_v3.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC control FSM: state encoding,
// variable indices, the registered control-output bundle and a config check.
package cordic_pkg;

   localparam logic [3:0] ST_IDLE       = 4'h0;
   localparam logic [3:0] ST_LOAD       = 4'h1;
   localparam logic [3:0] ST_ITER_SETUP = 4'h2;
   localparam logic [3:0] ST_ADD_START  = 4'h3;
   localparam logic [3:0] ST_ADD_WAIT   = 4'h4;
   localparam logic [3:0] ST_ADD_ACK    = 4'h5;
   localparam logic [3:0] ST_OUT_SEL    = 4'h6;
   localparam logic [3:0] ST_OUT_REG    = 4'h7;
   localparam logic [3:0] ST_DONE       = 4'h8;
   localparam logic [3:0] ST_ERROR      = 4'h9;

   typedef enum logic [3:0] {
      S_IDLE       = ST_IDLE,
      S_LOAD       = ST_LOAD,
      S_ITER_SETUP = ST_ITER_SETUP,
      S_ADD_START  = ST_ADD_START,
      S_ADD_WAIT   = ST_ADD_WAIT,
      S_ADD_ACK    = ST_ADD_ACK,
      S_OUT_SEL    = ST_OUT_SEL,
      S_OUT_REG    = ST_OUT_REG,
      S_DONE       = ST_DONE,
      S_ERROR      = ST_ERROR
   } state_e;

   localparam logic [1:0] VAR_X = 2'd0;
   localparam logic [1:0] VAR_Y = 2'd1;
   localparam logic [1:0] VAR_Z = 2'd2;

   // Registered single-bit control outputs towards requester and datapath
   typedef struct packed {
      logic ready;
      logic busy;
      logic err;
      logic beg_add;
      logic ack_add;
      logic sel1;
      logic sel3;
      logic rb1;
      logic rb2;
      logic xn;
      logic yn;
      logic zn;
      logic sh_x;
      logic sh_y;
      logic lut;
      logic sign;
      logic dff5;
      logic dout;
   } ctrl_t;

   // Iteration count must fit the index counter and allow at least two passes
   function automatic bit iter_cfg_ok(input int unsigned n_iter, input int unsigned iter_w);
      return (n_iter >= 2) && (iter_w >= 1) && (iter_w < 32) && (n_iter <= (32'd1 << iter_w));
   endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// Loadable, enabled up-counter with terminal-count flag; exposes its next
// value so callers can register decodes in step with the count.
module cordic_iter_counter #(
   parameter int unsigned W  = 2,
   parameter int unsigned TC = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic [W-1:0] o_count_nxt_c,
   output logic         o_tc_c
);

   logic [W-1:0] r_count;

   always_comb begin
      o_count_nxt_c = r_count;
      if (i_load) begin
         o_count_nxt_c = i_load_val;
      end else if (i_en) begin
         o_count_nxt_c = r_count + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else begin
         r_count <= o_count_nxt_c;
      end
   end

   assign o_count = r_count;
   assign o_tc_c  = (r_count == W'(TC));

endmodule

// File: rtl/cordic_fsm_v3.sv
// Control FSM for the iterative CORDIC sine/cosine datapath: sequences the
// X/Y/Z add/subtract handshakes per iteration, with a watchdog on the adder.
module cordic_fsm_v3 #(
   parameter int unsigned N_ITER  = 16,
   parameter int unsigned ITER_W  = 5,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              beg_FSM_CORDIC,
   input  logic              ACK_FSM_CORDIC,
   input  logic              operation,
   input  logic              mode_in,
   input  logic [1:0]        shift_region_flag,
   input  logic              ready_add_subt,
   output logic              ready_CORDIC,
   output logic              busy,
   output logic              err_add_subt,
   output logic              beg_add_subt,
   output logic              ack_add_subt,
   output logic              sel_mux_1,
   output logic [1:0]        sel_mux_2,
   output logic              sel_mux_3,
   output logic              mode,
   output logic [ITER_W-1:0] cont_iter,
   output logic [1:0]        cont_var,
   output logic              enab_RB1,
   output logic              enab_RB2,
   output logic              enab_d_ff_Xn,
   output logic              enab_d_ff_Yn,
   output logic              enab_d_ff_Zn,
   output logic              enab_dff_shifted_x,
   output logic              enab_dff_shifted_y,
   output logic              enab_dff_LUT,
   output logic              enab_dff_sign,
   output logic              enab_dff5,
   output logic              enab_d_ff_out
);

   import cordic_pkg::*;

   if (!iter_cfg_ok(N_ITER, ITER_W)) begin : g_bad_iter_cfg
      $error("cordic_fsm_v3: N_ITER must lie in 2..2**ITER_W");
   end
   if ((TIMEOUT < 1) || (TO_W >= 32) || (TIMEOUT > ((32'd1 << TO_W) - 1))) begin : g_bad_to_cfg
      $error("cordic_fsm_v3: TIMEOUT must lie in 1..2**TO_W-1");
   end

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_op;
   logic              r_mode;
   logic [1:0]        r_flag;
   logic [TO_W-1:0]   r_wd;
   ctrl_t             r_ctrl;
   ctrl_t             w_ctrl;

   logic              w_latch;
   logic              w_wd_clr;
   logic              w_wd_inc;
   logic              w_iter_load;
   logic              w_iter_en;
   logic              w_var_load;
   logic              w_var_en;
   logic [ITER_W-1:0] w_iter;
   logic [ITER_W-1:0] w_iter_nxt;
   logic              w_iter_tc;
   logic [1:0]        w_var;
   logic [1:0]        w_var_nxt;
   logic              w_var_tc;
   logic              w_op_nxt;
   logic              w_mode_nxt;
   logic [1:0]        w_flag_nxt;

   cordic_iter_counter #(
      .W  (ITER_W),
      .TC (N_ITER - 1)
   ) u_iter_cnt (
      .clk           (clk),
      .reset         (reset),
      .i_load        (w_iter_load),
      .i_load_val    ('0),
      .i_en          (w_iter_en),
      .o_count       (w_iter),
      .o_count_nxt_c (w_iter_nxt),
      .o_tc_c        (w_iter_tc)
   );

   cordic_iter_counter #(
      .W  (2),
      .TC (32'(VAR_Z))
   ) u_var_cnt (
      .clk           (clk),
      .reset         (reset),
      .i_load        (w_var_load),
      .i_load_val    (VAR_X),
      .i_en          (w_var_en),
      .o_count       (w_var),
      .o_count_nxt_c (w_var_nxt),
      .o_tc_c        (w_var_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus counter, watchdog and latch controls
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_wd_clr    = 1'b0;
      w_wd_inc    = 1'b0;
      w_iter_load = 1'b0;
      w_iter_en   = 1'b0;
      w_var_load  = 1'b0;
      w_var_en    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (beg_FSM_CORDIC) begin
               w_state_nxt = S_LOAD;
               w_latch     = 1'b1;
               w_wd_clr    = 1'b1;
               w_iter_load = 1'b1;
               w_var_load  = 1'b1;
            end
         end
         S_LOAD:       w_state_nxt = S_ITER_SETUP;
         S_ITER_SETUP: w_state_nxt = S_ADD_START;
         S_ADD_START: begin
            w_wd_clr    = 1'b1;
            w_state_nxt = S_ADD_WAIT;
         end
         S_ADD_WAIT: begin
            if (ready_add_subt) begin
               w_state_nxt = S_ADD_ACK;
            end else begin
               w_wd_inc = 1'b1;
               if (r_wd == TO_W'(TIMEOUT - 1)) begin
                  w_state_nxt = S_ERROR;
               end
            end
         end
         S_ADD_ACK: begin
            if (!w_var_tc) begin
               w_var_en    = 1'b1;
               w_state_nxt = S_ADD_START;
            end else if (!w_iter_tc) begin
               w_var_load  = 1'b1;
               w_iter_en   = 1'b1;
               w_state_nxt = S_ITER_SETUP;
            end else begin
               w_state_nxt = S_OUT_SEL;
            end
         end
         S_OUT_SEL: w_state_nxt = S_OUT_REG;
         S_OUT_REG: w_state_nxt = S_DONE;
         S_DONE:    if (ACK_FSM_CORDIC) w_state_nxt = S_IDLE;
         S_ERROR:   if (ACK_FSM_CORDIC) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   assign w_op_nxt   = w_latch ? operation         : r_op;
   assign w_mode_nxt = w_latch ? mode_in           : r_mode;
   assign w_flag_nxt = w_latch ? shift_region_flag : r_flag;

   // Moore decode of the upcoming state, registered so outputs track r_state
   always_comb begin
      w_ctrl      = '0;
      w_ctrl.busy = (w_state_nxt != S_IDLE);
      w_ctrl.sel3 = (w_state_nxt != S_IDLE) & (w_op_nxt ^ w_flag_nxt[1] ^ w_flag_nxt[0]);
      case (w_state_nxt)
         S_LOAD: w_ctrl.rb1 = 1'b1;
         S_ITER_SETUP: begin
            w_ctrl.rb2  = 1'b1;
            w_ctrl.sh_x = 1'b1;
            w_ctrl.sh_y = 1'b1;
            w_ctrl.lut  = 1'b1;
            w_ctrl.sign = 1'b1;
            w_ctrl.sel1 = (w_iter_nxt != '0);
         end
         S_ADD_START: w_ctrl.beg_add = 1'b1;
         S_ADD_ACK: begin
            w_ctrl.ack_add = 1'b1;
            w_ctrl.xn      = (w_var_nxt == VAR_X);
            w_ctrl.yn      = (w_var_nxt == VAR_Y);
            w_ctrl.zn      = (w_var_nxt == VAR_Z);
         end
         S_OUT_SEL: w_ctrl.dff5  = 1'b1;
         S_OUT_REG: w_ctrl.dout  = 1'b1;
         S_DONE:    w_ctrl.ready = 1'b1;
         S_ERROR:   w_ctrl.err   = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op   <= 1'b0;
         r_mode <= 1'b0;
         r_flag <= 2'b00;
         r_ctrl <= '0;
      end else begin
         r_op   <= w_op_nxt;
         r_mode <= w_mode_nxt;
         r_flag <= w_flag_nxt;
         r_ctrl <= w_ctrl;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wd <= '0;
      end else if (w_wd_clr) begin
         r_wd <= '0;
      end else if (w_wd_inc) begin
         r_wd <= r_wd + TO_W'(1);
      end
   end

   assign ready_CORDIC       = r_ctrl.ready;
   assign busy               = r_ctrl.busy;
   assign err_add_subt       = r_ctrl.err;
   assign beg_add_subt       = r_ctrl.beg_add;
   assign ack_add_subt       = r_ctrl.ack_add;
   assign sel_mux_1          = r_ctrl.sel1;
   assign sel_mux_2          = w_var;
   assign sel_mux_3          = r_ctrl.sel3;
   assign mode               = r_mode;
   assign cont_iter          = w_iter;
   assign cont_var           = w_var;
   assign enab_RB1           = r_ctrl.rb1;
   assign enab_RB2           = r_ctrl.rb2;
   assign enab_d_ff_Xn       = r_ctrl.xn;
   assign enab_d_ff_Yn       = r_ctrl.yn;
   assign enab_d_ff_Zn       = r_ctrl.zn;
   assign enab_dff_shifted_x = r_ctrl.sh_x;
   assign enab_dff_shifted_y = r_ctrl.sh_y;
   assign enab_dff_LUT       = r_ctrl.lut;
   assign enab_dff_sign      = r_ctrl.sign;
   assign enab_dff5          = r_ctrl.dff5;
   assign enab_d_ff_out      = r_ctrl.dout;

endmodule

// File: tb/tb_cordic_fsm_v3.sv
// Self-checking bench for cordic_fsm_v3: directed and randomized transactions
// compared against cycle-count and sequencing expectations.
module tb_cordic_fsm_v3;

   localparam int unsigned N_ITER  = 4;
   localparam int unsigned ITER_W  = 5;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned TO_W    = 8;
   localparam int          BUDGET  = 2000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              beg_FSM_CORDIC = 1'b0;
   logic              ACK_FSM_CORDIC = 1'b0;
   logic              operation = 1'b0;
   logic              mode_in = 1'b0;
   logic [1:0]        shift_region_flag = 2'b00;
   logic              ready_add_subt = 1'b0;
   logic              ready_CORDIC, busy, err_add_subt, beg_add_subt, ack_add_subt;
   logic              sel_mux_1, sel_mux_3, mode;
   logic [1:0]        sel_mux_2, cont_var;
   logic [ITER_W-1:0] cont_iter;
   logic              enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
   logic              enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign;
   logic              enab_dff5, enab_d_ff_out;

   int n_vec = 0;
   int n_bad = 0;
   int t_done_k, t_err_k, t_beg_cnt, t_first_beg_k;

   cordic_fsm_v3 #(
      .N_ITER (N_ITER), .ITER_W (ITER_W), .TIMEOUT (TIMEOUT), .TO_W (TO_W)
   ) dut (
      .clk (clk), .reset (reset),
      .beg_FSM_CORDIC (beg_FSM_CORDIC), .ACK_FSM_CORDIC (ACK_FSM_CORDIC),
      .operation (operation), .mode_in (mode_in),
      .shift_region_flag (shift_region_flag), .ready_add_subt (ready_add_subt),
      .ready_CORDIC (ready_CORDIC), .busy (busy), .err_add_subt (err_add_subt),
      .beg_add_subt (beg_add_subt), .ack_add_subt (ack_add_subt),
      .sel_mux_1 (sel_mux_1), .sel_mux_2 (sel_mux_2), .sel_mux_3 (sel_mux_3),
      .mode (mode), .cont_iter (cont_iter), .cont_var (cont_var),
      .enab_RB1 (enab_RB1), .enab_RB2 (enab_RB2),
      .enab_d_ff_Xn (enab_d_ff_Xn), .enab_d_ff_Yn (enab_d_ff_Yn), .enab_d_ff_Zn (enab_d_ff_Zn),
      .enab_dff_shifted_x (enab_dff_shifted_x), .enab_dff_shifted_y (enab_dff_shifted_y),
      .enab_dff_LUT (enab_dff_LUT), .enab_dff_sign (enab_dff_sign),
      .enab_dff5 (enab_dff5), .enab_d_ff_out (enab_d_ff_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int expected_latency(input int w);
      return 1 + N_ITER * (1 + 3 * (2 + w)) + 2;
   endfunction

   function automatic logic [31:0] outs_vec();
      return 32'({ready_CORDIC, busy, err_add_subt, beg_add_subt, ack_add_subt, sel_mux_1,
                  sel_mux_2, sel_mux_3, mode, cont_iter, cont_var, enab_RB1, enab_RB2,
                  enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff_shifted_x,
                  enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign, enab_dff5, enab_d_ff_out});
   endfunction

   // rmode: 0 = adder ready held high, 1 = ready w cycles after each start, 2 = never ready
   task automatic run_txn(input bit op, input bit md, input logic [1:0] fl,
                          input int rmode, input int w, input bit scramble);
      int nbeg, nack, nset, prev_beg, pend;
      nbeg = 0; nack = 0; nset = 0; prev_beg = 0; pend = -1;
      t_done_k = -1; t_err_k = -1; t_first_beg_k = -1;
      beg_FSM_CORDIC = 1'b1; operation = op; mode_in = md; shift_region_flag = fl;
      ready_add_subt = (rmode == 0);
      @(negedge clk);
      beg_FSM_CORDIC = 1'b0;
      for (int k = 0; k < BUDGET; k++) begin
         if (enab_RB2) begin
            check("setup_iter", 32'(cont_iter), 32'(nset));
            check("sel_mux_1", 32'(sel_mux_1), 32'(nset != 0));
            nset++;
         end
         if (beg_add_subt) begin
            if (nbeg == 0) t_first_beg_k = k;
            else if (nbeg % 3 != 0) check("var_period", 32'(k - prev_beg), 32'(2 + w));
            prev_beg = k; pend = k; nbeg++;
         end
         if (ack_add_subt) begin
            check("ack_cont_var", 32'(cont_var), 32'(nack % 3));
            check("ack_sel_mux_2", 32'(sel_mux_2), 32'(nack % 3));
            check("ack_enab_xyz", 32'({enab_d_ff_Zn, enab_d_ff_Yn, enab_d_ff_Xn}),
                  32'(1 << (nack % 3)));
            check("ack_iter", 32'(cont_iter), 32'(nack / 3));
            nack++; pend = -1;
         end
         if (ready_CORDIC) begin t_done_k = k; break; end
         if (err_add_subt) begin t_err_k = k; break; end
         case (rmode)
            0:       ready_add_subt = 1'b1;
            1:       ready_add_subt = (pend >= 0) && (k == pend + w);
            default: ready_add_subt = 1'b0;
         endcase
         if (scramble) begin
            beg_FSM_CORDIC    = 1'($urandom);
            operation         = 1'($urandom);
            mode_in           = 1'($urandom);
            shift_region_flag = 2'($urandom);
         end
         @(negedge clk);
      end
      t_beg_cnt = nbeg;
   endtask

   task automatic post_checks(input bit op, input bit md, input logic [1:0] fl, input int w);
      check("latency", 32'(t_done_k), 32'(expected_latency(w)));
      check("beg_pulses", 32'(t_beg_cnt), 32'(3 * N_ITER));
      check("sel_mux_3", 32'(sel_mux_3), 32'(op ^ fl[1] ^ fl[0]));
      check("mode_latched", 32'(mode), 32'(md));
      check("done_busy", 32'(busy), 32'd1);
   endtask

   task automatic ack_result(input int hold, input bit with_beg, input bit is_err);
      beg_FSM_CORDIC = 1'b0; ready_add_subt = 1'b0; ACK_FSM_CORDIC = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (is_err) check("err_hold", 32'(err_add_subt), 32'd1);
         else        check("ready_hold", 32'(ready_CORDIC), 32'd1);
      end
      ACK_FSM_CORDIC = 1'b1; beg_FSM_CORDIC = with_beg;
      @(negedge clk);
      check("ack_to_idle", 32'({busy, ready_CORDIC, err_add_subt}), 32'd0);
      ACK_FSM_CORDIC = 1'b0; beg_FSM_CORDIC = 1'b0;
      @(negedge clk);
      check("no_restart", 32'(busy), 32'd0);
   endtask

   initial begin
      bit          r_op, r_md, r_wb;
      logic [1:0]  r_fl;
      int          r_rm, r_w;
      bit          hit;

      @(negedge clk);
      check("reset_outputs", outs_vec(), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_outputs", outs_vec(), 32'd0);

      // Nominal sine run, then a long-held result and ACK coinciding with beg
      run_txn(1'b1, 1'b0, 2'b00, 0, 1, 1'b0);
      post_checks(1'b1, 1'b0, 2'b00, 1);
      ack_result(20, 1'b1, 1'b0);

      run_txn(1'b0, 1'b1, 2'b01, 0, 1, 1'b0);
      post_checks(1'b0, 1'b1, 2'b01, 1);
      ack_result(0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 2'b11, 0, 1, 1'b0);
      post_checks(1'b0, 1'b0, 2'b11, 1);
      ack_result(1, 1'b0, 1'b0);

      // Slow adder, and ready landing on the same cycle the watchdog expires
      run_txn(1'b1, 1'b0, 2'b10, 1, 5, 1'b0);
      post_checks(1'b1, 1'b0, 2'b10, 5);
      ack_result(0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b1, 2'b00, 1, TIMEOUT, 1'b0);
      post_checks(1'b0, 1'b1, 2'b00, TIMEOUT);
      ack_result(0, 1'b0, 1'b0);

      run_txn(1'b1, 1'b1, 2'b01, 2, 1, 1'b0);
      check("first_beg_k", 32'(t_first_beg_k), 32'd2);
      check("err_k", 32'(t_err_k), 32'(2 + 1 + TIMEOUT));
      check("err_beg_pulses", 32'(t_beg_cnt), 32'd1);
      check("err_no_ready", 32'(ready_CORDIC), 32'd0);
      check("err_busy", 32'(busy), 32'd1);
      ack_result(3, 1'b0, 1'b1);

      // Reset asserted while iteration 2 is being set up
      beg_FSM_CORDIC = 1'b1; operation = 1'b1; mode_in = 1'b1; shift_region_flag = 2'b10;
      ready_add_subt = 1'b1;
      @(negedge clk);
      beg_FSM_CORDIC = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < BUDGET && !hit; i++) begin
         if (enab_RB2 && (cont_iter == ITER_W'(2))) hit = 1'b1;
         else @(negedge clk);
      end
      check("reach_iter2", 32'(cont_iter), 32'd2);
      #2 reset = 1'b0;
      #1 check("reset_async", outs_vec(), 32'd0);
      @(negedge clk);
      reset = 1'b1; ready_add_subt = 1'b0;
      @(negedge clk);
      check("reset_idle", outs_vec(), 32'd0);
      run_txn(1'b1, 1'b0, 2'b00, 0, 1, 1'b0);
      post_checks(1'b1, 1'b0, 2'b00, 1);
      ack_result(0, 1'b0, 1'b0);

      // Randomized transactions with inputs toggling while busy
      for (int r = 0; r < 12; r++) begin
         r_op = 1'($urandom);
         r_md = 1'($urandom);
         r_fl = 2'($urandom);
         r_wb = 1'($urandom);
         r_rm = int'($urandom_range(0, 1));
         r_w  = (r_rm == 1) ? int'($urandom_range(1, TIMEOUT)) : 1;
         run_txn(r_op, r_md, r_fl, r_rm, r_w, 1'b1);
         post_checks(r_op, r_md, r_fl, r_w);
         ack_result(int'($urandom_range(0, 3)), r_wb, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
